// File: rtl/au_stream_stats_pkg.sv
// Shared definitions for the stream-statistics sequencer and its abs/max/min unit.
package au_stream_stats_pkg;

   // AU opcodes, presented to the unit as {c1, c0}
   localparam logic [1:0] OP_ABS = 2'b00;
   localparam logic [1:0] OP_MAX = 2'b01;
   localparam logic [1:0] OP_MIN = 2'b10;

   // Sequencer state encodings, 3-bit binary
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ABS  = 3'd1;
   localparam logic [2:0] ST_MAX  = 3'd2;
   localparam logic [2:0] ST_MIN  = 3'd3;
   localparam logic [2:0] ST_MABS = 3'd4;
   localparam logic [2:0] ST_OUT  = 3'd5;

endpackage

// File: rtl/au_stream_stats_abs_max_min.sv
// Combinational abs/max/min unit. Ordering uses the sign of the wrapped
// difference a-b, and abs of the most negative value stays negative; callers
// keep |a-b| below 2^(WIDTH-1) for in-range results.
module abs_max_min #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             c1_i,
   input  logic             c0_i,
   output logic [WIDTH-1:0] result_o
);

   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] c1_v;
   logic [WIDTH-1:0] c0_v;
   logic [WIDTH-1:0] lt_v;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH-1:0] max_ab;
   logic [WIDTH-1:0] min_ab;

   // control bits and the a<b flag replicated across the datapath width
   always_comb begin
      diff     = a_i - b_i;
      c1_v     = {WIDTH{c1_i}};
      c0_v     = {WIDTH{c0_i}};
      lt_v     = {WIDTH{diff[WIDTH-1]}};
      abs_b    = b_i[WIDTH-1] ? (~b_i + 1'b1) : b_i;
      max_ab   = (lt_v & b_i) | (~lt_v & a_i);
      min_ab   = (lt_v & a_i) | (~lt_v & b_i);
      result_o = (c1_v & min_ab) | (~c1_v & c0_v & max_ab) | (~c1_v & ~c0_v & abs_b);
   end

endmodule

// File: rtl/au_stream_stats.sv
// Per-frame max / min / max-magnitude over a signed sample stream, sharing a
// single abs_max_min unit across four compute states per sample.
//
// state | meaning
// IDLE  | waiting for a sample, in_ready high
// ABS   | mag <= abs(sample)
// MAX   | run_max <= max(run_max, sample)
// MIN   | run_min <= min(run_min, sample)
// MABS  | run_maxabs <= max(run_maxabs, mag); frame ends here if last
// OUT   | frame result presented until out_ready
module au_stream_stats
   import au_stream_stats_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_max,
   output logic [WIDTH-1:0] out_min,
   output logic [WIDTH-1:0] out_maxabs,
   output logic [CNT_W-1:0] out_count,
   output logic             busy
);

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] sample_q, sample_d;
   logic [WIDTH-1:0] mag_q, mag_d;
   logic [WIDTH-1:0] run_max_q, run_max_d;
   logic [WIDTH-1:0] run_min_q, run_min_d;
   logic [WIDTH-1:0] run_maxabs_q, run_maxabs_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             first_q, first_d;
   logic             last_q, last_d;

   logic [1:0]       au_op;
   logic [WIDTH-1:0] au_a, au_b, au_res;

   abs_max_min #(.WIDTH(WIDTH)) u_au (
      .a_i      (au_a),
      .b_i      (au_b),
      .c1_i     (au_op[1]),
      .c0_i     (au_op[0]),
      .result_o (au_res)
   );

   // AU operands and opcode come only from state and registers; on the first
   // sample of a frame the running value is replaced by the sample itself
   always_comb begin
      au_op = OP_ABS;
      au_a  = sample_q;
      au_b  = sample_q;
      unique case (state_q)
         ST_MAX: begin
            au_op = OP_MAX;
            au_a  = first_q ? sample_q : run_max_q;
         end
         ST_MIN: begin
            au_op = OP_MIN;
            au_a  = first_q ? sample_q : run_min_q;
         end
         ST_MABS: begin
            au_op = OP_MAX;
            au_a  = first_q ? mag_q : run_maxabs_q;
            au_b  = mag_q;
         end
         default: ;
      endcase
   end

   // next-state and register-update logic; each result register captures the
   // AU only in its own state
   always_comb begin
      state_d      = state_q;
      sample_d     = sample_q;
      mag_d        = mag_q;
      run_max_d    = run_max_q;
      run_min_d    = run_min_q;
      run_maxabs_d = run_maxabs_q;
      count_d      = count_q;
      first_d      = first_q;
      last_d       = last_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               sample_d = in_data;
               last_d   = in_last;
               count_d  = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;
               state_d  = ST_ABS;
            end
         end
         ST_ABS: begin
            mag_d   = au_res;
            state_d = ST_MAX;
         end
         ST_MAX: begin
            run_max_d = au_res;
            state_d   = ST_MIN;
         end
         ST_MIN: begin
            run_min_d = au_res;
            state_d   = ST_MABS;
         end
         ST_MABS: begin
            run_maxabs_d = au_res;
            first_d      = 1'b0;
            state_d      = last_q ? ST_OUT : ST_IDLE;
         end
         ST_OUT: begin
            if (out_ready) begin
               count_d = '0;
               first_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state and datapath registers; reset discards any partial frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         sample_q     <= '0;
         mag_q        <= '0;
         run_max_q    <= '0;
         run_min_q    <= '0;
         run_maxabs_q <= '0;
         count_q      <= '0;
         first_q      <= 1'b1;
         last_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sample_q     <= sample_d;
         mag_q        <= mag_d;
         run_max_q    <= run_max_d;
         run_min_q    <= run_min_d;
         run_maxabs_q <= run_maxabs_d;
         count_q      <= count_d;
         first_q      <= first_d;
         last_q       <= last_d;
      end
   end

   // handshake and status decode; in_ready stays low while reset is held
   always_comb begin
      in_ready   = (state_q == ST_IDLE) && rst_n;
      out_valid  = (state_q == ST_OUT);
      busy       = (state_q != ST_IDLE);
      out_max    = run_max_q;
      out_min    = run_min_q;
      out_maxabs = run_maxabs_q;
      out_count  = count_q;
   end

endmodule
